// File: rtl/asu_pkg.sv
// Shared mode encodings and FSM state type for the add/subtract/shift unit.
package asu_pkg;
  localparam logic [1:0] MODE_ADD = 2'b00;
  localparam logic [1:0] MODE_SUB = 2'b01;
  localparam logic [1:0] MODE_LSR = 2'b10;
  localparam logic [1:0] MODE_ASR = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } state_t;
endpackage

// File: rtl/asu_addsub.sv
// Combinational WIDTH-bit adder/subtractor; carry is carry-out on add, borrow on sub.
// ASU_SAT_EN selects saturating results (all ones on add overflow, zero on sub underflow).
module asu_addsub #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic [WIDTH-1:0] sum,
  output logic             carry
);
  logic [WIDTH:0] raw;

  always_comb begin
    raw = sub ? ({1'b0, a} - {1'b0, b}) : ({1'b0, a} + {1'b0, b});
    // The extra top bit is the carry-out on add and goes high on sub exactly when a < b.
    carry = raw[WIDTH];
`ifdef ASU_SAT_EN
    if (raw[WIDTH]) sum = sub ? '0 : '1;
    else            sum = raw[WIDTH-1:0];
`else
    sum = raw[WIDTH-1:0];
`endif
  end
endmodule

// File: rtl/asu_pipe.sv
// Add/sub (latency 1) and bit-serial shift unit (latency N+1) with valid/ready handshake.
// Optional macro ASU_SAT_EN enables saturating add/sub in asu_addsub.
module asu_pipe
  import asu_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int SHAMT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             carry,
  output logic             busy
);
  state_t             state;
  logic               arith;
  logic [SHAMT_W-1:0] cnt;
  logic [SHAMT_W-1:0] shamt;
  logic [WIDTH-1:0]   as_sum;
  logic               as_carry;

  assign shamt     = y[SHAMT_W-1:0];
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);

  asu_addsub #(.WIDTH(WIDTH)) u_addsub (
    .a     (x),
    .b     (y),
    .sub   (mode == MODE_SUB),
    .sum   (as_sum),
    .carry (as_carry)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      out   <= '0;
      carry <= 1'b0;
      arith <= 1'b0;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            if (mode == MODE_ADD || mode == MODE_SUB) begin
              out   <= as_sum;
              carry <= as_carry;
              state <= DONE;
            end else begin
              // Shift modes load x unshifted; one bit moves per SHIFT cycle.
              out   <= x;
              carry <= 1'b0;
              arith <= (mode == MODE_ASR);
              cnt   <= shamt;
              state <= (shamt == '0) ? DONE : SHIFT;
            end
          end
        end
        SHIFT: begin
          out   <= {arith & out[WIDTH-1], out[WIDTH-1:1]};
          carry <= out[0];
          cnt   <= cnt - SHAMT_W'(1);
          if (cnt == SHAMT_W'(1)) state <= DONE;
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/asu_pipe.md
ASU_PIPE -- requirements
Module: asu_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 8: operand and result width, legal range 4..32.
REQ-002 SHALL have derived parameter SHAMT_W, default $clog2(WIDTH): shift-amount field width.
REQ-003 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1: reset, synchronous, active-low.
REQ-005 SHALL have port in_valid, input, 1: request present.
REQ-006 SHALL have port in_ready, output, 1: block can accept a request.
REQ-007 SHALL have port mode, input, 2: 00 add, 01 subtract x-y, 10 logical shift right, 11 arithmetic shift right.
REQ-008 SHALL have ports x and y, input, WIDTH each: operands; y[SHAMT_W-1:0] is the shift amount in shift modes.
REQ-009 SHALL have port out_valid, output, 1: result present.
REQ-010 SHALL have port out_ready, input, 1: consumer takes result.
REQ-011 SHALL have port out, output, WIDTH: result.
REQ-012 SHALL have port carry, output, 1: carry-out, borrow, or last bit shifted out.
REQ-013 SHALL have port busy, output, 1: high whenever state is not IDLE.

Function
REQ-014 SHALL implement FSM IDLE, SHIFT, DONE; in_ready = (state==IDLE); out_valid = (state==DONE).
REQ-015 Accept = in_valid && in_ready at a rising edge; x, y, mode SHALL be captured only on accept and ignored otherwise.
REQ-016 Add/sub accept: IDLE->DONE; result and carry registered; out_valid high on the cycle after accept (latency 1).
REQ-017 Add: {carry,out} = x+y, WIDTH+1 bits; sub: out = x-y mod 2^WIDTH, carry = 1 iff x<y unsigned.
REQ-018 Shift accept with amount 0: IDLE->DONE, out = x, carry = 0, latency 1.
REQ-019 Shift accept with amount N>0: IDLE->SHIFT; one bit shifted per cycle; carry takes each bit shifted out; SHIFT->DONE when N bits done; out_valid exactly N+1 cycles after accept.
REQ-020 Logical shift fills MSB with 0; arithmetic shift replicates MSB.
REQ-021 DONE: out and carry SHALL hold stable until out_valid && out_ready, then DONE->IDLE; new request accepted no earlier than the following cycle.
REQ-022 in_valid during SHIFT or DONE SHALL have no effect.

Reset
REQ-023 rst_n low at a rising edge SHALL force state IDLE, out = 0, carry = 0, out_valid = 0, busy = 0, in_ready = 1 from the next cycle, aborting any shift or held result.
REQ-024 Reset SHALL take priority over accept and over out_ready in the same cycle.

Configuration
REQ-025 Macro ASU_SAT_EN defined: add overflow SHALL yield out = all ones, carry = 1; sub underflow SHALL yield out = 0, carry = 1; shifts unchanged.
REQ-026 ASU_SAT_EN undefined: add/sub SHALL wrap modulo 2^WIDTH per REQ-017.

Structure
REQ-027 Package asu_pkg SHALL hold the mode encodings (MODE_ADD, MODE_SUB, MODE_LSR, MODE_ASR) and the FSM state typedef.
REQ-028 Add/subtract datapath SHALL be sub-module asu_addsub (combinational, WIDTH-parametrised, outputs sum and carry/borrow); shift and FSM live in asu_pipe.

Verification (WIDTH=8)
REQ-029 Add x=8'hF0 y=8'h20 -> next cycle out_valid, out=8'h10 carry=1; with ASU_SAT_EN out=8'hFF carry=1.
REQ-030 Sub x=8'h05 y=8'h07 -> out=8'hFE carry=1; with ASU_SAT_EN out=8'h00 carry=1.
REQ-031 ASR x=8'h90 y=8'h03 -> out_valid 4 cycles after accept, out=8'hF2 carry=0; LSR x=8'h0F y=8'h02 -> out=8'h03 carry=1 after 3 cycles.
REQ-032 Shift with y=8'h08 (amount field 0) -> out=x, carry=0, latency 1.
REQ-033 Hold out_ready low 5 cycles in DONE with in_valid high -> out/carry unchanged, in_ready=0, no extra accept; release -> IDLE next cycle.
REQ-034 LSR amount 7, rst_n low on 3rd SHIFT cycle -> next cycle out_valid=0, out=0, carry=0, busy=0, in_ready=1.
